// File: rtl/f3m_serial_mult.sv
// Trit-serial multiplier over F_{3^97}, modulus x^97 + x^12 + 2.
// Horner accumulation consumes one trit of b per clock, most significant trit first.
module f3m_serial_mult (
    input  logic         clk,
    input  logic         reset,
    input  logic [193:0] a,
    input  logic [193:0] b,
    output logic [193:0] c,
    output logic         done
);

    localparam int unsigned N_TRITS = 97;
    localparam int unsigned W       = 2 * N_TRITS;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned LAST    = N_TRITS - 1;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic [W-1:0]     w_acc_x;
    logic [W-1:0]     w_acc_next;
    logic [W-1:0]     w_b_next;
    logic [1:0]       w_top;
    logic [1:0]       w_digit;
    logic             w_last;

    // Trit addition mod 3; never produces the illegal code 11.
    function automatic logic [1:0] f_tadd(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] s;
        s = 3'(x) + 3'(y);
        case (s)
            3'd0, 3'd3: f_tadd = 2'b00;
            3'd1, 3'd4: f_tadd = 2'b01;
            3'd2, 3'd5: f_tadd = 2'b10;
            default:    f_tadd = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] f_tneg(input logic [1:0] x);
        case (x)
            2'b01:   f_tneg = 2'b10;
            2'b10:   f_tneg = 2'b01;
            default: f_tneg = 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] f_tscale(input logic [1:0] x, input logic [1:0] d);
        case (d)
            2'b01:   f_tscale = x;
            2'b10:   f_tscale = f_tneg(x);
            default: f_tscale = 2'b00;
        endcase
    endfunction

    // Next accumulator: acc*x reduced (x^97 = 2x^12 + 1) plus digit * A.
    always_comb begin
        w_acc_x    = '0;
        w_acc_next = '0;
        w_top      = r_acc[W-1 -: 2];
        w_digit    = r_b[W-1 -: 2];
        w_b_next   = {r_b[W-3:0], 2'b00};
        w_last     = (r_cnt == CNT_W'(LAST));

        w_acc_x        = {r_acc[W-3:0], w_top};
        w_acc_x[25:24] = f_tadd(r_acc[23:22], f_tneg(w_top));

        for (int i = 0; i < int'(N_TRITS); i++) begin
            w_acc_next[2*i +: 2] = f_tadd(w_acc_x[2*i +: 2], f_tscale(r_a[2*i +: 2], w_digit));
        end
    end

    // Operands captured on reset; frozen once done is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= a;
            r_b    <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!r_done) begin
            r_acc  <= w_acc_next;
            r_b    <= w_b_next;
            r_cnt  <= r_cnt + CNT_W'(1);
            r_done <= w_last;
        end
    end

    assign c    = r_acc;
    assign done = r_done;

endmodule

// File: tb/tb_f3m_serial_mult.sv
// Self-checking bench for f3m_serial_mult against a schoolbook polynomial model.
module tb_f3m_serial_mult;

    logic         clk;
    logic         reset;
    logic [193:0] a;
    logic [193:0] b;
    logic [193:0] c;
    logic         done;

    int total;
    int bad;

    localparam logic [193:0] SC1_B = 194'h2a8aa25aa245066106a40806618aa88a2946881162a864652;

    f3m_serial_mult dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full polynomial product, then fold x^k (k>=97) as x^(k-97)*(2x^12 + 1).
    function automatic logic [193:0] model_mul(input logic [193:0] x, input logic [193:0] y);
        int p [193];
        int xi;
        int yj;
        int cf;
        logic [193:0] r;
        for (int k = 0; k < 193; k++) p[k] = 0;
        for (int i = 0; i < 97; i++) begin
            xi = int'(x[2*i +: 2]);
            for (int j = 0; j < 97; j++) begin
                yj = int'(y[2*j +: 2]);
                p[i+j] = p[i+j] + xi * yj;
            end
        end
        for (int k = 192; k >= 97; k--) begin
            cf = p[k] % 3;
            p[k - 97 + 12] = p[k - 97 + 12] + 2 * cf;
            p[k - 97]      = p[k - 97] + cf;
            p[k] = 0;
        end
        r = '0;
        for (int k = 0; k < 97; k++) r[2*k +: 2] = 2'(p[k] % 3);
        return r;
    endfunction

    function automatic logic [193:0] rand_vec();
        logic [193:0] v;
        v = '0;
        for (int i = 0; i < 97; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
        return v;
    endfunction

    function automatic bit has_illegal(input logic [193:0] v);
        bit f;
        f = 1'b0;
        for (int i = 0; i < 97; i++) if (v[2*i +: 2] == 2'b11) f = 1'b1;
        return f;
    endfunction

    task automatic start_op(input logic [193:0] av, input logic [193:0] bv);
        @(negedge clk);
        reset = 1'b1;
        a     = av;
        b     = bv;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts edges until done rises, bounded; optionally scrambles inputs meanwhile.
    task automatic wait_done(output int edges, input bit scramble);
        edges = 0;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
            if (scramble) begin
                a = rand_vec();
                b = rand_vec();
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        reset = 1'b1;
        a = 194'h5;
        b = 194'h5;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (c !== 194'h0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: c=%h done=%b want c=0 done=0", c, done);
        end
        a = 194'h2;
        b = 194'h2;
        @(negedge clk);
        reset = 1'b0;
        wait_done(edges, 1'b0);
        total++;
        if (c !== 194'h1 || edges != 97) begin
            bad++;
            $display("FAIL reset_last_sample: c=%h edges=%0d want c=1 edges=97", c, edges);
        end
    endtask

    task automatic test_identity();
        int edges;
        start_op(194'h1, SC1_B);
        wait_done(edges, 1'b0);
        total++;
        if (edges != 97) begin
            bad++;
            $display("FAIL identity_latency: edges=%0d want 97", edges);
        end
        total++;
        if (c !== SC1_B) begin
            bad++;
            $display("FAIL identity_value: c=%h want %h", c, SC1_B);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done !== 1'b1 || c !== SC1_B) begin
            bad++;
            $display("FAIL identity_hold: done=%b c=%h", done, c);
        end
    endtask

    task automatic test_reduction();
        int edges;
        logic [193:0] bv;
        bv = '0;
        bv[192] = 1'b1;
        start_op(194'h4, bv);
        wait_done(edges, 1'b0);
        total++;
        if (c !== 194'h2000001 || edges != 97) begin
            bad++;
            $display("FAIL reduction: c=%h edges=%0d want c=2000001 edges=97", c, edges);
        end
    endtask

    task automatic test_small();
        int edges;
        start_op(194'h5, 194'ha);
        wait_done(edges, 1'b0);
        total++;
        if (c !== 194'h26) begin
            bad++;
            $display("FAIL small_poly: c=%h want 26", c);
        end
        start_op(194'h2, 194'h2);
        wait_done(edges, 1'b0);
        total++;
        if (c !== 194'h1) begin
            bad++;
            $display("FAIL two_times_two: c=%h want 1", c);
        end
    endtask

    task automatic test_zero_commute();
        int edges;
        start_op(194'h0, SC1_B);
        wait_done(edges, 1'b0);
        total++;
        if (c !== 194'h0) begin
            bad++;
            $display("FAIL zero_operand: c=%h want 0", c);
        end
        start_op(SC1_B, 194'h1);
        wait_done(edges, 1'b0);
        total++;
        if (c !== SC1_B) begin
            bad++;
            $display("FAIL commute: c=%h want %h", c, SC1_B);
        end
    endtask

    task automatic test_mid_reset();
        int edges;
        int early;
        logic [193:0] bv;
        bv = '0;
        bv[192] = 1'b1;
        early = 0;
        start_op(194'h4, bv);
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) early++;
        end
        start_op(194'h2, 194'h2);
        wait_done(edges, 1'b0);
        total++;
        if (early != 0 || edges != 97 || c !== 194'h1) begin
            bad++;
            $display("FAIL mid_reset: early=%0d edges=%0d c=%h want 0/97/1", early, edges, c);
        end
    endtask

    task automatic test_idle_hold();
        int edges;
        logic [193:0] av;
        logic [193:0] bv;
        logic [193:0] exp_c;
        av = rand_vec();
        bv = rand_vec();
        exp_c = model_mul(av, bv);
        start_op(av, bv);
        wait_done(edges, 1'b0);
        for (int k = 0; k < 20; k++) begin
            a = rand_vec();
            b = rand_vec();
            @(negedge clk);
            total++;
            if (c !== exp_c || done !== 1'b1) begin
                bad++;
                $display("FAIL idle_hold[%0d]: c=%h done=%b want %h 1", k, c, done, exp_c);
            end
        end
    endtask

    task automatic test_random();
        int edges;
        logic [193:0] av;
        logic [193:0] bv;
        logic [193:0] exp_c;
        for (int n = 0; n < 12; n++) begin
            av = rand_vec();
            bv = rand_vec();
            exp_c = model_mul(av, bv);
            start_op(av, bv);
            wait_done(edges, n[0]);
            total++;
            if (c !== exp_c || edges != 97) begin
                bad++;
                $display("FAIL random[%0d]: c=%h edges=%0d want %h 97", n, c, edges, exp_c);
            end
            total++;
            if (has_illegal(c)) begin
                bad++;
                $display("FAIL random_code[%0d]: c=%h has trit 11", n, c);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a     = '0;
        b     = '0;
        test_reset();
        test_identity();
        test_reduction();
        test_small();
        test_zero_commute();
        test_mid_reset();
        test_idle_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
